ahbl_uart_rx: RTL and testbench

- AHB-Lite slave UART receiver: 8N1 frames, 16x oversampling, 8-entry RX FIFO, level interrupt.
- Receive-side counterpart of the existing ahbl_uart_tx.
- Sits on a crossbar slave port.
- Received bytes are read by the CPU, or by the DMAC via the IRQ/PIRQ request line.

---
 rtl/ahbl_uart_rx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ahbl_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_uart_rx.sv
// ahbl_uart_rx: AHB-Lite UART receiver, 8N1, 16x oversampling, RX FIFO, level IRQ.
// Ports: AHB-Lite slave (HCLK/HRESETn/H*), rx serial in, IRQ level out.
module ahbl_uart_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             dp_valid;
  logic             dp_write;
  logic [1:0]       dp_addr;
  logic             dp_done;
  logic             wr_en;
  logic             pop;

  logic [2:0]       ctrl_q;
  logic [DIV_W-1:0] baud_q;
  logic             en;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  logic             rx_s1;
  logic             rx_s2;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic [7:0]       sh_q;
  logic [7:0]       sh_d;
  logic             push;
  logic             fe_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [CW-1:0]    level_q;
  logic             ne;
  logic             full;
  logic             push_ok;
  logic             ovr_set;
  logic             ovr_q;
  logic             fe_q;
  logic [31:0]      status;

  logic             unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  assign dp_done = dp_valid & HREADY;
  assign wr_en   = dp_done & dp_write;
  assign pop     = dp_done & ~dp_write & (dp_addr == 2'd0) & ne;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q <= 3'd0;
      baud_q <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        (dp_addr == 2'd2): ctrl_q <= HWDATA[2:0];
        (dp_addr == 2'd3): baud_q <= HWDATA[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  assign en = ctrl_q[0];

  // >= so that lowering BAUDDIV while running cannot strand the counter
  assign tick = en & (div_cnt >= baud_q);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
    end else if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s2) begin
            state_d = S_START;
            cnt_d   = 4'd0;
          end
        end
        S_START: begin
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            idx_d   = 3'd0;
            state_d = rx_s2 ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            sh_d  = {rx_s2, sh_q[7:1]};
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = S_STOP;
            end
          end
        end
        S_STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            push    = rx_s2;
            fe_set  = ~rx_s2;
            state_d = rx_s2 ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (rx_s2) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ne      = (level_q != '0);
  assign full    = (level_q == CW'(FIFO_DEPTH));
  // when full, the slot being popped this cycle is the one written
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_ff @(posedge HCLK) begin
    if (push_ok) begin
      mem[wp_q] <= sh_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wp_q <= wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= rp_q + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovr_q <= ovr_set |
               (ovr_q & ~(wr_en & (dp_addr == 2'd1) & HWDATA[2]));
      fe_q  <= fe_set |
               (fe_q & ~(wr_en & (dp_addr == 2'd1) & HWDATA[3]));
    end
  end

  always_comb begin
    status          = '0;
    status[0]       = ne;
    status[1]       = full;
    status[2]       = ovr_q;
    status[3]       = fe_q;
    status[4 +: CW] = level_q;
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      unique case (dp_addr)
        2'd0: HRDATA[7:0] = ne ? mem[rp_q] : 8'd0;
        2'd1: HRDATA = status;
        2'd2: HRDATA[2:0] = ctrl_q;
        2'd3: HRDATA[DIV_W-1:0] = baud_q;
        default: ;
      endcase
    end
  end

  assign IRQ = (ctrl_q[1] & ne) | (ctrl_q[2] & (ovr_q | fe_q));

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// tb_ahbl_uart_rx: directed bench for ahbl_uart_rx.
// Drives AHB-Lite accesses and 8N1 serial frames, checks registers/IRQ.
module tb_ahbl_uart_rx;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        rx;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  ahbl_uart_rx #(
    .FIFO_DEPTH(8),
    .DIV_W(16)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .HADDR(HADDR),
    .HTRANS(HTRANS),
    .HSIZE(HSIZE),
    .HWRITE(HWRITE),
    .HREADY(HREADY),
    .HSEL(HSEL),
    .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA),
    .rx(rx),
    .IRQ(IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge HCLK);
    #1;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = 1'b1;
    @(posedge HCLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = d;
    @(posedge HCLK);
    #1;
    HWDATA = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK);
    #1;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = 1'b0;
    @(posedge HCLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    d      = HRDATA;
    @(posedge HCLK);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // start bit + 8 data bits, returns with last data bit still on rx
  task automatic send_bits(input logic [7:0] b, input int bc);
    @(posedge HCLK);
    #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (bc) @(posedge HCLK);
      #1 rx = b[i];
    end
    repeat (bc) @(posedge HCLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bc);
    send_bits(b, bc);
    #1 rx = 1'b1;
    repeat (bc) @(posedge HCLK);
    #1;
  endtask

  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_CTRL = 32'h8;
  localparam logic [31:0] A_BAUD = 32'hC;

  initial begin
    logic [31:0] d;
    HRESETn = 1'b0;
    HADDR   = '0;
    HTRANS  = 2'b00;
    HSIZE   = 3'b010;
    HWRITE  = 1'b0;
    HREADY  = 1'b1;
    HSEL    = 1'b0;
    HWDATA  = '0;
    rx      = 1'b1;

    // reset
    wait_cyc(3);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd_chk("rst_status", A_STAT, 32'h00);
    rd_chk("rst_data", A_DATA, 32'h00);
    rd_chk("rst_ctrl", A_CTRL, 32'h00);
    rd_chk("rst_baud", A_BAUD, 32'h00);

    // single byte at 64 cycles/bit
    bus_wr(A_BAUD, 32'd3);
    bus_wr(A_CTRL, 32'h3);
    rd_chk("baud_rb", A_BAUD, 32'd3);
    send_bits(8'hA5, 64);
    #1 rx = 1'b1;
    wait_cyc(4);
    chk("single_irq_pre", {31'd0, IRQ}, 32'd0);
    wait_cyc(60);
    chk("single_irq", {31'd0, IRQ}, 32'd1);
    rd_chk("single_status", A_STAT, 32'h11);
    rd_chk("single_data", A_DATA, 32'hA5);
    rd_chk("single_status_empty", A_STAT, 32'h00);
    chk("single_irq_clr", {31'd0, IRQ}, 32'd0);
    chk("hreadyout_1", {31'd0, HREADYOUT}, 32'd1);

    // glitch shorter than half a bit
    #1 rx = 1'b0;
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(200);
    rd_chk("glitch_status", A_STAT, 32'h00);

    // overrun
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 64);
    end
    rd_chk("ovr_status", A_STAT, 32'h87);
    chk("ovr_irq", {31'd0, IRQ}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      rd_chk("ovr_data", A_DATA, 32'(i));
    end
    rd_chk("ovr_drained", A_STAT, 32'h04);
    bus_wr(A_STAT, 32'h4);
    rd_chk("ovr_cleared", A_STAT, 32'h00);

    // framing error and break
    bus_wr(A_CTRL, 32'h5);
    chk("fe_irq_pre", {31'd0, IRQ}, 32'd0);
    send_bits(8'h3C, 64);
    #1 rx = 1'b0;
    wait_cyc(3 * 64);
    rd_chk("fe_status", A_STAT, 32'h08);
    chk("fe_irq", {31'd0, IRQ}, 32'd1);
    rx = 1'b1;
    wait_cyc(64);
    send_byte(8'h55, 64);
    rd_chk("fe_next_status", A_STAT, 32'h19);
    rd_chk("fe_next_data", A_DATA, 32'h55);
    bus_wr(A_STAT, 32'h8);
    rd_chk("fe_cleared", A_STAT, 32'h00);
    chk("fe_irq_clr", {31'd0, IRQ}, 32'd0);

    // EN dropped mid-frame keeps FIFO, drops partial byte
    bus_wr(A_CTRL, 32'h3);
    send_byte(8'h5A, 64);
    #1 rx = 1'b0;
    wait_cyc(3 * 64);
    bus_wr(A_CTRL, 32'h0);
    rx = 1'b1;
    wait_cyc(10);
    bus_wr(A_CTRL, 32'h3);
    wait_cyc(12 * 64);
    rd_chk("abort_status", A_STAT, 32'h11);
    rd_chk("abort_data", A_DATA, 32'h5A);

    // full FIFO, pop coincides with push, BAUDDIV = 0
    bus_wr(A_BAUD, 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i), 16);
    end
    rd_chk("bnd_full", A_STAT, 32'h83);
    fork
      send_byte(8'h18, 16);
      begin
        repeat (153) @(posedge HCLK);
        bus_rd(A_DATA, d);
      end
    join
    chk("bnd_pop_data", d, 32'h10);
    rd_chk("bnd_status", A_STAT, 32'h83);
    for (int i = 1; i <= 8; i++) begin
      rd_chk("bnd_order", A_DATA, 32'h10 + 32'(i));
    end
    rd_chk("bnd_empty", A_STAT, 32'h00);
    send_byte(8'hFF, 16);
    send_byte(8'h00, 16);
    rd_chk("fast_ff", A_DATA, 32'hFF);
    rd_chk("fast_00", A_DATA, 32'h00);
    rd_chk("fast_status", A_STAT, 32'h00);
    chk("hreadyout_2", {31'd0, HREADYOUT}, 32'd1);

    // reset in mid-operation clears everything at once
    send_byte(8'h77, 16);
    chk("mrst_irq_pre", {31'd0, IRQ}, 32'd1);
    @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    chk("mrst_irq", {31'd0, IRQ}, 32'd0);
    wait_cyc(2);
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd_chk("mrst_status", A_STAT, 32'h00);
    rd_chk("mrst_ctrl", A_CTRL, 32'h00);
    rd_chk("mrst_baud", A_BAUD, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
